// File: rtl/cpu_defs.sv
// Shared definitions for the EXE-stage HI/LO unit: divider state encoding,
// operand width and the bit positions of the packed quotient/remainder result.
package cpu_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH = 32;

   localparam int DIV_Q_MSB = 2 * DIV_WIDTH - 1;
   localparam int DIV_Q_LSB = DIV_WIDTH;
   localparam int DIV_R_MSB = DIV_WIDTH - 1;
   localparam int DIV_R_LSB = 0;

endpackage

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider. Takes one dividend/divisor pair per
// WIDTH+2 cycles and returns {quotient, remainder} with a single-cycle valid pulse.
module iter_div
   import cpu_defs::*;
#(
   parameter bit SIGNED = 1'b0,
   parameter int WIDTH  = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_axis_dividend_tvalid,
   output logic                 s_axis_dividend_tready,
   input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
   input  logic                 s_axis_divisor_tvalid,
   output logic                 s_axis_divisor_tready,
   input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
   output logic                 m_axis_dout_tvalid,
   output logic [2*WIDTH-1:0]   m_axis_dout_tdata
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_t         r_state;
   div_state_t         w_nextState;
   logic [CW-1:0]      r_count;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dsr;
   logic [WIDTH-1:0]   r_quo;
   logic               r_qNeg;
   logic               r_rNeg;
   logic [2*WIDTH-1:0] r_dout;

   logic               w_ready;
   logic               w_valid;
   logic               w_accept;
   logic               w_last;
   logic               w_dvdNeg;
   logic               w_dsrNeg;
   logic [WIDTH-1:0]   w_dvdMag;
   logic [WIDTH-1:0]   w_dsrMag;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH+1:0]   w_diff;
   logic               w_fits;
   logic [WIDTH-1:0]   w_qNext;
   logic [WIDTH-1:0]   w_rNext;

   // Operand magnitudes; the most negative value maps onto itself, which is the
   // correct unsigned magnitude and gives the wrapping overflow result.
   always_comb begin
      w_dvdNeg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
      w_dsrNeg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
      w_dvdMag = w_dvdNeg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
      w_dsrMag = w_dsrNeg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
   end

   // One restoring step; a zero divisor always fits, yielding q = all ones, r = |dividend|.
   always_comb begin
      w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
      w_diff  = {1'b0, w_shift} - {2'b00, r_dsr};
      w_fits  = ~w_diff[WIDTH+1];
      w_qNext = {r_quo[WIDTH-2:0], w_fits};
      w_rNext = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_last  = (r_count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Handshake outputs decode only state and reset, so reset wins in any cycle.
   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_valid     = 1'b0;
      w_accept    = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ready  = ~reset;
            w_accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
            if (w_accept) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (w_last) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_valid     = ~reset;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // The sign-fixed result is loaded on the final iteration so it is ready in DONE,
   // and it then holds until the next result or a reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dsr   <= '0;
         r_quo   <= '0;
         r_qNeg  <= 1'b0;
         r_rNeg  <= 1'b0;
         r_dout  <= '0;
      end else if (w_accept) begin
         r_count <= '0;
         r_rem   <= '0;
         r_dvd   <= w_dvdMag;
         r_dsr   <= w_dsrMag;
         r_quo   <= '0;
         r_qNeg  <= w_dvdNeg ^ w_dsrNeg;
         r_rNeg  <= w_dvdNeg;
      end else if (r_state == BUSY) begin
         r_rem   <= w_fits ? w_diff[WIDTH:0] : w_shift;
         r_quo   <= w_qNext;
         r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
         r_count <= r_count + CW'(1);
         if (w_last) begin
            r_dout <= {(r_qNeg ? -w_qNext : w_qNext), (r_rNeg ? -w_rNext : w_rNext)};
         end
      end
   end

   assign s_axis_dividend_tready = w_ready;
   assign s_axis_divisor_tready  = w_ready;
   assign m_axis_dout_tvalid     = w_valid;
   assign m_axis_dout_tdata      = r_dout;

endmodule
